// File: rtl/exp2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exp2_pkg
//  Description : Shared widths and constants for the 2^x fraction evaluator
//                datapath. Also provides the elaboration-time helper that
//                builds the 128-entry 2^(i/128) table in Q3.13.
//  Contents    : EXP2_IN_W, EXP2_OUT_W, EXP2_ONE, EXP2_ERR_SENT, EXP2_GAP,
//                EXP2_LUT_AW, exp2_lut_entry()
//  Revision    : 1.0  initial release
// ============================================================================
package exp2_pkg;

    localparam int                EXP2_IN_W     = 13;
    localparam int                EXP2_OUT_W    = 16;
    localparam logic [15:0]       EXP2_ONE      = 16'h2000;
    localparam logic [12:0]       EXP2_ERR_SENT = 13'h1FFF;
    localparam logic [12:0]       EXP2_GAP      = 13'd2166;

    // Table address width: the operand is truncated to its top 7 bits,
    // giving 128 evenly spaced fraction points in [0,1).
    localparam int                EXP2_LUT_AW   = 7;

    // Fixed-point roots 2^(1/2^n) scaled by 1e18. Each table entry is the
    // product of the roots selected by the set bits of its index, so no
    // long iteration is needed at elaboration time.
    localparam logic [127:0]      EXP2_SCALE    = 128'd1000000000000000000;
    localparam logic [127:0]      EXP2_HALF     = 128'd500000000000000000;
    localparam logic [127:0]      EXP2_R2       = 128'd1414213562373095049;
    localparam logic [127:0]      EXP2_R4       = 128'd1189207115002721067;
    localparam logic [127:0]      EXP2_R8       = 128'd1090507732665257659;
    localparam logic [127:0]      EXP2_R16      = 128'd1044273782427413840;
    localparam logic [127:0]      EXP2_R32      = 128'd1021897148654116678;
    localparam logic [127:0]      EXP2_R64      = 128'd1010889286051700460;
    localparam logic [127:0]      EXP2_R128     = 128'd1005429901112802821;

    // round(8192 * 2^(idx/128)); constant function, evaluated at elaboration.
    function automatic logic [EXP2_OUT_W-1:0] exp2_lut_entry(
        input logic [EXP2_LUT_AW-1:0] idx
    );
        logic [127:0] acc;
        acc = EXP2_SCALE;
        if (idx[6]) acc = (acc * EXP2_R2   + EXP2_HALF) / EXP2_SCALE;
        if (idx[5]) acc = (acc * EXP2_R4   + EXP2_HALF) / EXP2_SCALE;
        if (idx[4]) acc = (acc * EXP2_R8   + EXP2_HALF) / EXP2_SCALE;
        if (idx[3]) acc = (acc * EXP2_R16  + EXP2_HALF) / EXP2_SCALE;
        if (idx[2]) acc = (acc * EXP2_R32  + EXP2_HALF) / EXP2_SCALE;
        if (idx[1]) acc = (acc * EXP2_R64  + EXP2_HALF) / EXP2_SCALE;
        if (idx[0]) acc = (acc * EXP2_R128 + EXP2_HALF) / EXP2_SCALE;
        acc = (acc * 128'd8192 + EXP2_HALF) / EXP2_SCALE;
        return EXP2_OUT_W'(acc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exp2_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : exp2_rr_arb
//  Description : Round-robin grant generator. Searches ptr, ptr+1, ... mod
//                NUM_REQ for the first active request. The pointer moves to
//                one past the granted requester only when the grant is used.
//  Ports       : clk, rst         clock, synchronous active-high reset
//                i_req  [N-1:0]   request vector
//                i_accept         grant consumed this cycle
//                o_grant[N-1:0]   one-hot grant (zero if no request)
//                o_grant_id       index of granted requester
//                o_any            at least one request active
//  Revision    : 1.0  initial release
// ============================================================================
module exp2_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_any
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_cand;
    logic [ID_W-1:0] w_id;
    logic            w_found;

    always_comb begin
        w_cand  = '0;
        w_id    = '0;
        w_found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = ID_W'((int'(r_ptr) + off) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_id    = w_cand;
            end
        end
    end

    assign o_grant    = w_found ? (NUM_REQ'(1) << w_id) : '0;
    assign o_grant_id = w_id;
    assign o_any      = w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= (w_id == ID_W'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lut_pos.sv
`default_nettype none
// ============================================================================
//  Module      : lut_pos
//  Description : Combinational 2^x evaluator for a positive Q0.13 fraction.
//                Result in Q3.13 (1.0 = 16'h2000). The operand is truncated
//                to a 128-point table. The sentinel 13'h1FFF and the
//                piecewise-gap point 13'd2166 fall back to 1.0.
//  Ports       : i_x [12:0]  operand, unsigned Q0.13
//                o_y [15:0]  2^x, Q3.13
//  Revision    : 1.0  initial release
// ============================================================================
module lut_pos
    import exp2_pkg::*;
(
    input  logic [EXP2_IN_W-1:0]  i_x,
    output logic [EXP2_OUT_W-1:0] o_y
);

    logic [EXP2_OUT_W-1:0]  w_lut [2**EXP2_LUT_AW];
    logic [EXP2_LUT_AW-1:0] w_idx;
    logic                   w_fallback;

    genvar gi;
    generate
        for (gi = 0; gi < 2**EXP2_LUT_AW; gi++) begin : g_lut
            localparam logic [EXP2_OUT_W-1:0] c_val =
                exp2_lut_entry(EXP2_LUT_AW'(gi));
            assign w_lut[gi] = c_val;
        end
    endgenerate

    assign w_idx      = i_x[EXP2_IN_W-1 -: EXP2_LUT_AW];
    assign w_fallback = (i_x == EXP2_ERR_SENT) | (i_x == EXP2_GAP);
    assign o_y        = w_fallback ? EXP2_ONE : w_lut[w_idx];

endmodule
`default_nettype wire

// File: rtl/exp2_lut_arb.sv
`default_nettype none
// ============================================================================
//  Module      : exp2_lut_arb
//  Description : Shares one lut_pos 2^x evaluator among NUM_REQ softmax
//                lanes. Round-robin arbitration, 2-stage pipeline
//                (operand register -> result register), valid/ready on both
//                sides, requester ID returned with every result.
//  Ports       : I_CLK, I_RST          clock, synchronous active-high reset
//                I_REQ_VLD/O_REQ_RDY   per-requester handshake
//                I_REQ_DATA            packed Q0.13 operands, lane k at 13k
//                O_RES_VLD/I_RES_RDY   result handshake
//                O_RES_DATA            2^x, Q3.13
//                O_RES_ID              requester index of the result
//                O_RES_ERR             operand hit the LUT fallback
//                O_BUSY                an item is in flight
//  Config      : EXP2_ARB_ERR_EN - when defined, O_RES_ERR flags sentinel
//                and gap operands; otherwise O_RES_ERR is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module exp2_lut_arb
    import exp2_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         I_CLK,
    input  logic                         I_RST,
    input  logic [NUM_REQ-1:0]           I_REQ_VLD,
    output logic [NUM_REQ-1:0]           O_REQ_RDY,
    input  logic [NUM_REQ*EXP2_IN_W-1:0] I_REQ_DATA,
    output logic                         O_RES_VLD,
    input  logic                         I_RES_RDY,
    output logic [EXP2_OUT_W-1:0]        O_RES_DATA,
    output logic [ID_W-1:0]              O_RES_ID,
    output logic                         O_RES_ERR,
    output logic                         O_BUSY
);

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_id;
    logic                  w_any;
    logic                  w_s1_adv;
    logic                  w_s1_load;
    logic                  w_accept;
    logic                  w_s2_load;
    logic [EXP2_IN_W-1:0]  w_opnd;
    logic [EXP2_OUT_W-1:0] w_lut_y;

    logic                  r_s1_vld;
    logic [EXP2_IN_W-1:0]  r_s1_data;
    logic [ID_W-1:0]       r_s1_id;
    logic                  r_s2_vld;
    logic [EXP2_OUT_W-1:0] r_s2_data;
    logic [ID_W-1:0]       r_s2_id;

    // Stage 2 drains when empty or consumed; stage 1 can refill whenever it
    // is empty or moving on, so ready only drops with both stages full.
    assign w_s1_adv  = ~r_s2_vld | I_RES_RDY;
    assign w_s1_load = ~r_s1_vld | w_s1_adv;
    assign w_accept  = w_any & w_s1_load;
    assign w_s2_load = r_s1_vld & w_s1_adv;

    exp2_rr_arb #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .clk        (I_CLK),
        .rst        (I_RST),
        .i_req      (I_REQ_VLD),
        .i_accept   (w_accept),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    assign O_REQ_RDY = w_grant & {NUM_REQ{w_s1_load}};

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_opnd = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_opnd = I_REQ_DATA[k*EXP2_IN_W +: EXP2_IN_W];
            end
        end
    end

    lut_pos u_lut (
        .i_x (r_s1_data),
        .o_y (w_lut_y)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_id   <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
            r_s2_id   <= '0;
        end else begin
            r_s1_vld <= w_accept | (r_s1_vld & ~w_s1_adv);
            if (w_accept) begin
                r_s1_data <= w_opnd;
                r_s1_id   <= w_grant_id;
            end
            r_s2_vld <= w_s2_load | (r_s2_vld & ~I_RES_RDY);
            if (w_s2_load) begin
                r_s2_data <= w_lut_y;
                r_s2_id   <= r_s1_id;
            end
        end
    end

`ifdef EXP2_ARB_ERR_EN
    logic w_err;
    logic r_s2_err;

    assign w_err = (r_s1_data == EXP2_ERR_SENT) | (r_s1_data == EXP2_GAP);

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_s2_err <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_err <= w_err;
        end
    end

    assign O_RES_ERR = r_s2_err;
`else
    assign O_RES_ERR = 1'b0;
`endif

    assign O_RES_VLD  = r_s2_vld;
    assign O_RES_DATA = r_s2_data;
    assign O_RES_ID   = r_s2_id;
    assign O_BUSY     = r_s1_vld | r_s2_vld;

endmodule
`default_nettype wire

// File: tb/tb_exp2_lut_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp2_lut_arb
//  Description : Self-checking bench for exp2_lut_arb. Accepted operands are
//                pushed into a scoreboard with the expected 2^x value,
//                computed with real arithmetic; a separate monitor pops and
//                compares every emitted result. Ready vectors are checked
//                against a round-robin model and pipeline occupancy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exp2_lut_arb;
    import exp2_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_REQ-1:0]           req_vld = '0;
    logic [NUM_REQ-1:0]           req_rdy;
    logic [NUM_REQ*EXP2_IN_W-1:0] req_data = '0;
    logic                         res_vld;
    logic                         res_rdy = 1'b1;
    logic [EXP2_OUT_W-1:0]        res_data;
    logic [ID_W-1:0]              res_id;
    logic                         res_err;
    logic                         busy;

    always #5 clk = ~clk;

    exp2_lut_arb #(.NUM_REQ(NUM_REQ)) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_REQ_VLD  (req_vld),
        .O_REQ_RDY  (req_rdy),
        .I_REQ_DATA (req_data),
        .O_RES_VLD  (res_vld),
        .I_RES_RDY  (res_rdy),
        .O_RES_DATA (res_data),
        .O_RES_ID   (res_id),
        .O_RES_ERR  (res_err),
        .O_BUSY     (busy)
    );

    typedef struct {
        int id;
        int data;
        int err;
    } sb_item_t;

    sb_item_t           sb[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 rr_ptr = 0;
    logic [NUM_REQ-1:0] acc_mask = '0;

    // ---------------- reference model ----------------
    function automatic int ref_exp2(input int v);
        real r;
        if (v == 8191 || v == 2166) return 32'h2000;
        r = 8192.0 * (2.0 ** (real'(v / 64) / 128.0));
        return $rtoi(r + 0.5);
    endfunction

    function automatic int ref_err(input int v);
`ifdef EXP2_ARB_ERR_EN
        return (v == 8191 || v == 2166) ? 1 : 0;
`else
        return (v < 0) ? 1 : 0;
`endif
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] vld, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (ptr + i) % NUM_REQ;
            if (vld[k]) return k;
        end
        return -1;
    endfunction

    function automatic int rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 8191;
            1:       return 2166;
            2:       return 0;
            3:       return 4096;
            default: return int'($urandom_range(0, 8191));
        endcase
    endfunction

    // ---------------- acceptance monitor: ready check + scoreboard push ----
    int                 pick;
    logic [NUM_REQ-1:0] exp_rdy;
    always @(negedge clk) begin
        cyc++;
        acc_mask = '0;
        if (!rst) begin
            pick = rr_pick(req_vld, rr_ptr);
            exp_rdy = '0;
            if (pick >= 0 && !(sb.size() == 2 && !res_rdy))
                exp_rdy = NUM_REQ'(1) << pick;
            checks++;
            if (req_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL req_rdy cyc=%0d got=%b exp=%b vld=%b", cyc, req_rdy, exp_rdy, req_vld);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_vld[k] && req_rdy[k]) begin
                    int v;
                    sb_item_t it;
                    v = int'(req_data[k*EXP2_IN_W +: EXP2_IN_W]);
                    it.id   = k;
                    it.data = ref_exp2(v);
                    it.err  = ref_err(v);
                    sb.push_back(it);
                    acc_mask[k] = 1'b1;
                    rr_ptr = (k + 1) % NUM_REQ;
                end
            end
        end
    end

    // ---------------- output monitor: stall stability + scoreboard pop -----
    logic                  stall_pending = 1'b0;
    logic [EXP2_OUT_W-1:0] held_data;
    logic [ID_W-1:0]       held_id;
    logic                  held_err;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                checks++;
                if (!(res_vld === 1'b1 && res_data === held_data &&
                      res_id === held_id && res_err === held_err)) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got vld=%b d=%h id=%0d e=%b exp d=%h id=%0d e=%b",
                             cyc, res_vld, res_data, res_id, res_err, held_data, held_id, held_err);
                end
            end
            stall_pending = res_vld & ~res_rdy;
            held_data = res_data;
            held_id   = res_id;
            held_err  = res_err;
            if (res_vld === 1'b1 && res_rdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected cyc=%0d got d=%h id=%0d exp none", cyc, res_data, res_id);
                end else begin
                    sb_item_t e;
                    e = sb.pop_front();
                    if (int'(res_data) != e.data || int'(res_id) != e.id || int'(res_err) != e.err) begin
                        errors++;
                        $display("FAIL result cyc=%0d got d=%h id=%0d e=%b exp d=%h id=%0d e=%0d",
                                 cyc, res_data, res_id, res_err, e.data, e.id, e.err);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // One cycle: retire accepted operands, optionally issue new ones on the
    // lanes in mask, and set downstream ready with the given probability.
    task automatic tick(input logic [NUM_REQ-1:0] mask, input int vld_pct, input int rdy_pct);
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acc_mask[k]) req_vld[k] = 1'b0;
            if (!req_vld[k] && mask[k] && int'($urandom_range(0, 99)) < vld_pct) begin
                req_vld[k] = 1'b1;
                req_data[k*EXP2_IN_W +: EXP2_IN_W] = EXP2_IN_W'(rand_opnd());
            end
        end
        res_rdy = (int'($urandom_range(0, 99)) < rdy_pct);
    endtask

    task automatic put(input int k, input int v);
        tick('0, 0, 100);
        req_vld[k] = 1'b1;
        req_data[k*EXP2_IN_W +: EXP2_IN_W] = EXP2_IN_W'(v);
        repeat (4) tick('0, 0, 100);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #3;
        chk("reset_vld",  int'(res_vld),  0);
        chk("reset_data", int'(res_data), 0);
        chk("reset_id",   int'(res_id),   0);
        chk("reset_err",  int'(res_err),  0);
        chk("reset_busy", int'(busy),     0);

        // Directed operands, including both fallback points
        put(0, 0);
        put(2, 4096);
        put(1, 1000);
        put(0, 8191);
        put(3, 2166);
        put(1, 8190);

        // All lanes saturated: one-hot ready and one accept per cycle
        repeat (16) tick('1, 100, 100);
        repeat (6)  tick('0, 0, 100);

        // Single streaming lane with a three-cycle downstream stall
        repeat (3)  tick(4'b1000, 100, 100);
        repeat (3)  tick(4'b1000, 100, 0);
        repeat (4)  tick(4'b1000, 100, 100);
        repeat (6)  tick('0, 0, 100);

        // Random traffic and back-pressure
        repeat (400) tick('1, 50, 70);
        repeat (8)   tick('0, 0, 100);

        // Fill both stages, then reset mid-flight
        repeat (4) tick(4'b1000, 100, 0);
        @(posedge clk);
        #1;
        req_vld = '0;
        res_rdy = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        rr_ptr  = 0;
        res_rdy = 1'b1;
        for (int k = 0; k < NUM_REQ; k++)
            req_data[k*EXP2_IN_W +: EXP2_IN_W] = EXP2_IN_W'(rand_opnd());
        req_vld = '1;
        @(negedge clk);
        #3;
        chk("post_reset_vld",  int'(res_vld), 0);
        chk("post_reset_busy", int'(busy),    0);
        repeat (10) tick('0, 0, 100);

        // Bounded drain
        begin
            int waited;
            waited = 0;
            while ((sb.size() != 0 || req_vld != '0) && waited < 50) begin
                tick('0, 0, 100);
                waited++;
            end
            chk("drain_left", sb.size() + int'(req_vld != '0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expired", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
